seven_seg_arbiter: RTL and testbench
====================================

Name: seven_seg_arbiter

Overview:
- Time-shares the single 4-digit seven-segment display between NUM_REQ independent requesters, each offering a 16-bit hex word.
- Round-robin grant with a fixed dwell time per grant, a per-requester done pulse and a blanking gap between messages.
- Sits directly upstream of the 4-digit multiplexed display driver and feeds its four nibble inputs plus a blank qualifier.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DWELL_CYCLES, 1000, clk cycles a granted word is shown (>=1).
- GAP_CYCLES, 16, blank clk cycles between consecutive grants (0 = no gap state).

Ports:
- clk  input  1  system clock; single clock domain, all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester display request, level-sensitive.
- req_data  input  16*NUM_REQ  requester i word at bits [16i+15:16i]; nibble 3 = leftmost digit.
- val3, val2, val1, val0  output  4 each  digit nibbles to display driver.
- blank  output  1  high = driver must show nothing.
- grant  output  NUM_REQ  one-hot owner of display, all-zero when none.
- done  output  NUM_REQ  one-cycle pulse to requester whose dwell completed normally.
- busy  output  1  high in SHOW or GAP.

Behaviour:
- Reset (rst high at posedge): state IDLE, val3..val0 = 0, blank = 1, grant = 0, done = 0, busy = 0, round-robin pointer last = NUM_REQ-1 (requester 0 wins first), counters 0. Reset overrides any in-flight grant; no done pulse issued.
- All outputs registered.
- States: IDLE, SHOW, GAP.
- IDLE:
  - If any req bit set, select the first set bit searching last+1, last+2, ... wrapping modulo NUM_REQ.
  - Next edge: grant one-hot = winner, last = winner, snapshot winner's req_data into val3..val0, blank = 0, busy = 1, dwell counter = 0, go SHOW.
  - Latency: req seen at edge N -> grant/values valid after edge N+1.
- SHOW:
  - Counter increments each cycle; grant stays high exactly DWELL_CYCLES cycles.
  - req_data changes ignored (snapshot held).
  - On the cycle counter == DWELL_CYCLES-1, next edge: grant = 0, done[winner] = 1 for one cycle, blank = 1, vals = 0, go GAP (or IDLE if GAP_CYCLES == 0).
  - Early withdraw: if req[winner] is low during SHOW, next edge behaves as dwell end but without done pulse.
  - Withdraw on the final dwell cycle: treated as withdraw, no done.
- GAP:
  - Blank = 1, busy = 1; stays GAP_CYCLES cycles, then IDLE.
  - Requests arriving in GAP are held by requester level and served from IDLE.
- Fairness: a requester holding req continuously is regranted only after every other active requester has had one grant.
- Single-requester case: regranted each pass; period = DWELL_CYCLES + GAP_CYCLES + 1 (the IDLE arbitration cycle).
- Counter widths: $clog2 of (DWELL_CYCLES+1) and (GAP_CYCLES+1); no wrap beyond terminal count.
- done and grant never both high for the same requester in the same cycle.

Optional Feature:
- Macro SEG_ARB_PRIORITY_EN.
- Defined:
  - Requester 0 is urgent. If req[0] rises while another requester is in SHOW, next edge ends that grant without done, skips GAP, and grants requester 0 directly (vals = req_data[15:0], fresh dwell).
  - Requester 0 also wins any IDLE arbitration.
  - last updates to 0 so round-robin resumes at requester 1.
- Undefined: pure round-robin, no preemption, requester 0 treated like others.

Test Plan (DWELL_CYCLES=4, GAP_CYCLES=2, NUM_REQ=4):
- Reset then req=0001, data0=16'h1234 -> after 1 cycle grant=0001, vals=1,2,3,4, blank=0 for 4 cycles; then done=0001 one cycle, blank=1 for 2 cycles, regrant 7 cycles after the first grant.
- req=1111 held, distinct words -> grant order 0001,0010,0100,1000,0001; each shown 4 cycles, each done pulses once per grant.
- req=0100 granted, drop req[2] after 2 SHOW cycles -> grant=0 next edge, done stays 0, GAP entered.
- Change data1 from 16'hABCD to 16'h0F0F mid-SHOW for requester 1 -> vals remain A,B,C,D until dwell ends.
- Assert rst during SHOW -> next edge all outputs at reset values, no done; req=0010 then granted first after reset.
- With SEG_ARB_PRIORITY_EN: requester 2 in SHOW, raise req[0] with 16'hBEEF -> next edge grant=0001, vals=B,E,E,F, no done to requester 2; afterwards round-robin resumes at requester 1.

Source files
------------

// File: rtl/seven_seg_arbiter.sv
// Round-robin arbiter time-sharing one 4-digit seven-segment display between NUM_REQ requesters.
// Optional: define SEG_ARB_PRIORITY_EN to make requester 0 urgent (preempts SHOW, wins every arbitration).
module seven_seg_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [3:0]             val3,
  output logic [3:0]             val2,
  output logic [3:0]             val1,
  output logic [3:0]             val0,
  output logic                   blank,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [LW-1:0] LAST_RST  = LW'(NUM_REQ - 1);
  localparam logic [DW-1:0] DWELL_END = DW'(DWELL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_END   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        last_q, last_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [15:0]          val_q, val_d;
  logic                 blank_q, blank_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [LW-1:0]        win;
  logic [LW-1:0]        cand;

  // Search starts just after the last winner so a continuously held request cannot starve others.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = LW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`ifdef SEG_ARB_PRIORITY_EN
    if (req[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    done_d  = '0;
    val_d   = val_q;
    blank_d = blank_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SHOW;
          grant_d = NUM_REQ'(1) << win;
          last_d  = win;
          val_d   = req_data[16*win +: 16];
          blank_d = 1'b0;
          busy_d  = 1'b1;
          dwell_d = '0;
        end
      end
      SHOW: begin
`ifdef SEG_ARB_PRIORITY_EN
        if (req[0] && (last_q != '0)) begin
          grant_d = NUM_REQ'(1);
          last_d  = '0;
          val_d   = req_data[15:0];
          dwell_d = '0;
        end else
`endif
        // last_q always holds the current owner while in SHOW.
        if (!req[last_q] || (dwell_q == DWELL_END)) begin
          grant_d = '0;
          blank_d = 1'b1;
          val_d   = '0;
          gap_d   = '0;
          if (req[last_q]) done_d = grant_q;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = GAP;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_END) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      dwell_q <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      val_q   <= '0;
      blank_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      val_q   <= val_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
    end
  end

  assign val3  = val_q[15:12];
  assign val2  = val_q[11:8];
  assign val1  = val_q[7:4];
  assign val0  = val_q[3:0];
  assign blank = blank_q;
  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Self-checking bench for seven_seg_arbiter: directed scenarios plus randomized traffic against a countdown model.
module tb_seven_seg_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int GP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [16*N-1:0] req_data;
  logic [3:0]      val3, val2, val1, val0;
  logic            blank;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;

  int tests = 0;
  int fails = 0;

  seven_seg_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(DW), .GAP_CYCLES(GP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .val3(val3), .val2(val2), .val1(val1), .val0(val0),
    .blank(blank), .grant(grant), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), dwell cycles remaining, gap cycles remaining.
  int           m_owner = -1;
  int           m_left  = 0;
  int           m_gap   = 0;
  int           m_last  = N - 1;
  logic [15:0]  m_data  = '0;
  logic [N-1:0] m_done  = '0;

  task automatic model_step();
    m_done = '0;
    if (rst) begin
      m_owner = -1;
      m_gap   = 0;
      m_last  = N - 1;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        m_gap   = GP;
      end else if (m_left == 1) begin
        m_done[m_owner] = 1'b1;
        m_owner = -1;
        m_gap   = GP;
      end else begin
        m_left = m_left - 1;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if (req != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c]) begin
          m_owner = c;
          break;
        end
      end
      m_last = m_owner;
      m_left = DW;
      m_data = req_data[16*m_owner +: 16];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    req_data[16*i +: 16] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] vals();
    return {val3, val2, val1, val0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_data = '0;
    tick();
    tick();
    tests++;
    if ({grant, done, blank, busy, vals()} !== {4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL reset_outputs: got grant=%b done=%b blank=%b busy=%b vals=%h, want 0000 0000 1 0 0000",
               grant, done, blank, busy, vals());
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_word(0, 16'h1234);
    req = 4'b0001;
    tick();
    for (int i = 0; i < DW; i++) begin
      tests++;
      if ({grant, blank, busy, done, vals()} !== {4'b0001, 1'b0, 1'b1, 4'b0000, 16'h1234}) begin
        fails++;
        $display("FAIL single_show[%0d]: got grant=%b blank=%b busy=%b done=%b vals=%h, want 0001 0 1 0000 1234",
                 i, grant, blank, busy, done, vals());
      end
      tick();
    end
    tests++;
    if ({grant, done, blank, busy, vals()} !== {4'b0000, 4'b0001, 1'b1, 1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL single_done: got grant=%b done=%b blank=%b busy=%b vals=%h, want 0000 0001 1 1 0000",
               grant, done, blank, busy, vals());
    end
    tick();
    tests++;
    if ({grant, done, blank, busy} !== {4'b0000, 4'b0000, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL single_gap2: got grant=%b done=%b blank=%b busy=%b, want 0000 0000 1 1",
               grant, done, blank, busy);
    end
    tick();
    tests++;
    if ({grant, blank, busy} !== {4'b0000, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL single_idle: got grant=%b blank=%b busy=%b, want 0000 1 0", grant, blank, busy);
    end
    tick();
    tests++;
    if ({grant, blank, vals()} !== {4'b0001, 1'b0, 16'h1234}) begin
      fails++;
      $display("FAIL single_regrant_at_7: got grant=%b blank=%b vals=%h, want 0001 0 1234", grant, blank, vals());
    end
  endtask

  task automatic test_round_robin();
    logic [15:0]  words [N];
    logic [N-1:0] exp_g;
    int           waited;
    int           cnt;
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, words[i]);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (grant == '0 && waited < 10) begin
        tick();
        waited++;
      end
      exp_g = N'(1) << (g % N);
      tests++;
      if ({grant, vals()} !== {exp_g, words[g % N]}) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got grant=%b vals=%h, want %b %h", g, grant, vals(), exp_g, words[g % N]);
      end
      cnt = 0;
      while (grant == exp_g && cnt < 20) begin
        cnt++;
        tick();
      end
      tests++;
      if (cnt !== DW) begin
        fails++;
        $display("FAIL rr_dwell[%0d]: got %0d cycles, want %0d", g, cnt, DW);
      end
      tests++;
      if (done !== exp_g) begin
        fails++;
        $display("FAIL rr_done[%0d]: got done=%b, want %b", g, done, exp_g);
      end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    set_word(2, 16'h5A5A);
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0000;
    tick();
    tests++;
    if ({grant, done, blank, busy} !== {4'b0000, 4'b0000, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL withdraw_end: got grant=%b done=%b blank=%b busy=%b, want 0000 0000 1 1",
               grant, done, blank, busy);
    end
    tick();
    tests++;
    if ({done, busy} !== {4'b0000, 1'b1}) begin
      fails++;
      $display("FAIL withdraw_nodone: got done=%b busy=%b, want 0000 1", done, busy);
    end
  endtask

  task automatic test_data_hold();
    do_reset();
    set_word(1, 16'hABCD);
    req = 4'b0010;
    tick();
    tick();
    set_word(1, 16'h0F0F);
    for (int i = 1; i < DW; i++) begin
      tests++;
      if ({grant, vals()} !== {4'b0010, 16'hABCD}) begin
        fails++;
        $display("FAIL hold_vals[%0d]: got grant=%b vals=%h, want 0010 abcd", i, grant, vals());
      end
      tick();
    end
    tests++;
    if ({grant, done, vals()} !== {4'b0000, 4'b0010, 16'h0000}) begin
      fails++;
      $display("FAIL hold_end: got grant=%b done=%b vals=%h, want 0000 0010 0000", grant, done, vals());
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    set_word(1, 16'h1111);
    set_word(2, 16'h2222);
    req = 4'b0100;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if ({grant, done, blank, busy, vals()} !== {4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL midreset_outputs: got grant=%b done=%b blank=%b busy=%b vals=%h, want 0000 0000 1 0 0000",
               grant, done, blank, busy, vals());
    end
    rst = 1'b0;
    req = 4'b0010;
    tick();
    tests++;
    if ({grant, done, vals()} !== {4'b0010, 4'b0000, 16'h1111}) begin
      fails++;
      $display("FAIL midreset_regrant: got grant=%b done=%b vals=%h, want 0010 0000 1111", grant, done, vals());
    end
  endtask

`ifdef SEG_ARB_PRIORITY_EN
  task automatic test_priority();
    int waited;
    do_reset();
    set_word(1, 16'h1111);
    set_word(2, 16'h2222);
    req = 4'b0100;
    tick();
    tick();
    set_word(0, 16'hBEEF);
    req = 4'b0101;
    tick();
    tests++;
    if ({grant, done, blank, vals()} !== {4'b0001, 4'b0000, 1'b0, 16'hBEEF}) begin
      fails++;
      $display("FAIL prio_preempt: got grant=%b done=%b blank=%b vals=%h, want 0001 0000 0 beef",
               grant, done, blank, vals());
    end
    req = 4'b0110;
    tick();
    waited = 0;
    while (grant == '0 && waited < 10) begin
      tick();
      waited++;
    end
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL prio_resume: got grant=%b, want 0010", grant);
    end
  endtask
`else
  task automatic test_random();
    logic [N-1:0]  eg;
    logic [15:0]   ev;
    do_reset();
    req = 4'b1011;
    for (int i = 0; i < N; i++) set_word(i, 16'($urandom));
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
        if ($urandom_range(0, 3) == 0) set_word(b, 16'($urandom));
      end
      tick();
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      ev = (m_owner >= 0) ? m_data : 16'h0000;
      tests++;
      if ({grant, done, blank, busy, vals()} !== {eg, m_done, (m_owner < 0), (m_owner >= 0 || m_gap > 0), ev}) begin
        fails++;
        $display("FAIL random[%0d]: got grant=%b done=%b blank=%b busy=%b vals=%h, want %b %b %b %b %h",
                 cyc, grant, done, blank, busy, vals(), eg, m_done, (m_owner < 0),
                 (m_owner >= 0 || m_gap > 0), ev);
      end
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_data_hold();
    test_reset_mid_show();
`ifdef SEG_ARB_PRIORITY_EN
    test_priority();
`else
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
